// File: rtl/calc_sequencer.sv
// Central control FSM of the slider calculator: operand A/B entry, result display,
// out-of-range detection and the blinking error indication.
module calc_sequencer #(
  parameter int unsigned WIDTH          = 14,
  parameter int unsigned MAX_VALUE      = 9999,
  parameter int unsigned BLINK_OVERFLOW = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_clr,
  input  logic             btn_ent,
  input  logic             btn_add,
  input  logic             btn_sub,
  input  logic [WIDTH-1:0] number_1,
  input  logic [WIDTH-1:0] number_2,
  input  logic [WIDTH-1:0] result,
  output logic             write_number_select,
  output logic             arithmetic_sel,
  output logic             slider_clr,
  output logic [WIDTH-1:0] display_number,
  output logic             display_blank,
  output logic [1:0]       state
);

  localparam int unsigned CNT_W = (BLINK_OVERFLOW > 0) ? $clog2(BLINK_OVERFLOW + 1) : 1;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    SHOW_RES = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic             sel_nxt;
  logic             clr_nxt;
  logic [WIDTH-1:0] res_q, res_nxt;
  logic [WIDTH-1:0] disp_nxt;
  logic             blank_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH:0]   sum_c;
  logic             eval_err_c;
  logic             add_ev_c, sub_ev_c;

  // Operation buttons only count when no higher-priority button is present.
  assign add_ev_c = btn_add & ~btn_clr & ~btn_ent;
  assign sub_ev_c = btn_sub & ~btn_clr & ~btn_ent;

  assign sum_c      = {1'b0, number_1} + {1'b0, number_2};
  assign eval_err_c = arithmetic_sel ? (number_2 > number_1)
                                     : (sum_c > (WIDTH+1)'(MAX_VALUE));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = arithmetic_sel;
    clr_nxt   = 1'b0;
    res_nxt   = res_q;
    disp_nxt  = '0;
    blank_nxt = 1'b0;
    cnt_nxt   = '0;

    if (btn_clr) begin
      state_nxt = ENTER_A;
      sel_nxt   = 1'b0;
      clr_nxt   = 1'b1;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (btn_ent)       state_nxt = ENTER_B;
          else if (sub_ev_c) sel_nxt   = 1'b1;
          else if (add_ev_c) sel_nxt   = 1'b0;
        end
        ENTER_B: begin
          if (btn_ent) begin
            if (eval_err_c) begin
              state_nxt = ERROR;
            end else begin
              state_nxt = SHOW_RES;
              res_nxt   = result;
            end
          end else if (sub_ev_c) begin
            sel_nxt = 1'b1;
          end else if (add_ev_c) begin
            sel_nxt = 1'b0;
          end
        end
        SHOW_RES, ERROR: begin
          if (btn_ent) begin
            state_nxt = ENTER_A;
            clr_nxt   = 1'b1;
          end
        end
        default: state_nxt = ENTER_A;
      endcase
    end

    // Display source follows the state being entered so it changes on the same edge.
    case (state_nxt)
      ENTER_A:  disp_nxt = number_1;
      ENTER_B:  disp_nxt = number_2;
      SHOW_RES: disp_nxt = res_nxt;
      default:  disp_nxt = '0;
    endcase

    if (state_nxt == ERROR) begin
      if (state_q != ERROR) begin
        blank_nxt = 1'b1;
        cnt_nxt   = '0;
      end else if (cnt_q == CNT_W'(BLINK_OVERFLOW)) begin
        blank_nxt = ~display_blank;
        cnt_nxt   = '0;
      end else begin
        blank_nxt = display_blank;
        cnt_nxt   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ENTER_A;
      arithmetic_sel      <= 1'b0;
      write_number_select <= 1'b0;
      slider_clr          <= 1'b0;
      display_blank       <= 1'b0;
      display_number      <= '0;
      res_q               <= '0;
      cnt_q               <= '0;
    end else begin
      state_q             <= state_nxt;
      arithmetic_sel      <= sel_nxt;
      write_number_select <= (state_nxt == ENTER_B);
      slider_clr          <= clr_nxt;
      display_blank       <= blank_nxt;
      display_number      <= disp_nxt;
      res_q               <= res_nxt;
      cnt_q               <= cnt_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a short blink period.
module tb_calc_sequencer;

  localparam int unsigned W  = 14;
  localparam int unsigned BO = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_clr = 1'b0, btn_ent = 1'b0, btn_add = 1'b0, btn_sub = 1'b0;
  logic [W-1:0] number_1 = '0, number_2 = '0;
  logic [W-1:0] result;
  logic         write_number_select, arithmetic_sel, slider_clr, display_blank;
  logic [W-1:0] display_number;
  logic [1:0]   state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0]   st;
    logic [W-1:0] dn;
  } exp_t;

  exp_t sb[$];
  logic exp_sel = 1'b0;

  always #5 clk = ~clk;

  // Arithmetic unit stand-in feeding the result port.
  assign result = arithmetic_sel ? number_1 - number_2 : number_1 + number_2;

  calc_sequencer #(.WIDTH(W), .MAX_VALUE(9999), .BLINK_OVERFLOW(BO)) dut (
    .clk(clk), .reset(reset),
    .btn_clr(btn_clr), .btn_ent(btn_ent), .btn_add(btn_add), .btn_sub(btn_sub),
    .number_1(number_1), .number_2(number_2), .result(result),
    .write_number_select(write_number_select), .arithmetic_sel(arithmetic_sel),
    .slider_clr(slider_clr), .display_number(display_number),
    .display_blank(display_blank), .state(state)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t e;
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (sub) begin
      if (b > a) e = '{st: 2'd3, dn: '0};
      else       e = '{st: 2'd2, dn: a - b};
    end else begin
      if (s > 15'd9999) e = '{st: 2'd3, dn: '0};
      else              e = '{st: 2'd2, dn: s[W-1:0]};
    end
    return e;
  endfunction

  // One-cycle button pulse; returns on the falling edge after the capturing edge.
  task automatic drive(input logic clr, input logic ent, input logic add, input logic sub);
    @(negedge clk);
    btn_clr = clr; btn_ent = ent; btn_add = add; btn_sub = sub;
    @(negedge clk);
    btn_clr = 1'b0; btn_ent = 1'b0; btn_add = 1'b0; btn_sub = 1'b0;
  endtask

  // From ENTER_A: load operands, optional op (1 add, 2 sub), enter twice, record expectation.
  task automatic run_eval(input logic [W-1:0] a, input logic [W-1:0] b, input int op);
    number_1 = a;
    number_2 = b;
    if (op == 1) begin drive(0, 0, 1, 0); exp_sel = 1'b0; end
    if (op == 2) begin drive(0, 0, 0, 1); exp_sel = 1'b1; end
    drive(0, 1, 0, 0);
    sb.push_back(model(a, b, exp_sel));
    drive(0, 1, 0, 0);
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (state != 2'd1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({state, arithmetic_sel, write_number_select, slider_clr, display_blank} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got st=%0d sel=%0b wns=%0b clr=%0b blank=%0b want all 0",
               state, arithmetic_sel, write_number_select, slider_clr, display_blank);
    end
    n_tests++;
    if (display_number !== '0) begin
      n_fail++; $display("FAIL reset_display got %0d want 0", display_number);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    exp_t e;
    logic ok;
    run_eval(14'd1234, 14'd4321, 1);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || display_number !== e.dn || display_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result got st=%0d dn=%0d blank=%0b want st=%0d dn=%0d blank=0",
               state, display_number, display_blank, e.st, e.dn);
    end
    number_2 = 14'd7;
    repeat (2) @(negedge clk);
    n_tests++;
    if (display_number !== 14'd5555) begin
      n_fail++; $display("FAIL result_frozen got %0d want 5555", display_number);
    end
    drive(0, 1, 0, 0);
    n_tests++;
    if (state !== 2'd0 || slider_clr !== 1'b1) begin
      n_fail++; $display("FAIL show_exit got st=%0d clr=%0b want st=0 clr=1", state, slider_clr);
    end
    number_1 = 14'd42;
    @(negedge clk);
    n_tests++;
    if (slider_clr !== 1'b0 || display_number !== 14'd42) begin
      n_fail++;
      $display("FAIL clr_width_a_pass got clr=%0b dn=%0d want clr=0 dn=42", slider_clr, display_number);
    end
  endtask

  task automatic test_boundary;
    exp_t e;
    logic ok;
    run_eval(14'd5000, 14'd4999, 0);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || display_number !== e.dn) begin
      n_fail++;
      $display("FAIL sum_max got st=%0d dn=%0d want st=%0d dn=%0d", state, display_number, e.st, e.dn);
    end
    drive(0, 1, 0, 0);
    run_eval(14'd5000, 14'd5000, 0);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || display_number !== e.dn) begin
      n_fail++;
      $display("FAIL sum_over got st=%0d dn=%0d want st=%0d dn=%0d", state, display_number, e.st, e.dn);
    end
  endtask

  // Entered ERROR on the last edge; blank pattern is 4 high, 4 low, 4 high.
  task automatic test_blink;
    logic want;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      want = ((i / 4) % 2) == 0;
      n_tests++;
      if (display_blank !== want || display_number !== '0) begin
        n_fail++;
        $display("FAIL blink_%0d got blank=%0b dn=%0d want blank=%0b dn=0", i, display_blank, display_number, want);
      end
    end
    drive(0, 1, 0, 0);
    n_tests++;
    if (state !== 2'd0 || slider_clr !== 1'b1 || display_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL error_exit got st=%0d clr=%0b blank=%0b want 0/1/0", state, slider_clr, display_blank);
    end
    @(negedge clk);
    n_tests++;
    if (slider_clr !== 1'b0) begin
      n_fail++; $display("FAIL error_exit_clr got %0b want 0", slider_clr);
    end
  endtask

  task automatic test_sub;
    exp_t e;
    logic ok;
    run_eval(14'd10, 14'd20, 2);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || display_number !== e.dn) begin
      n_fail++;
      $display("FAIL sub_neg got st=%0d dn=%0d want st=%0d dn=%0d", state, display_number, e.st, e.dn);
    end
    drive(0, 1, 0, 0);
    run_eval(14'd20, 14'd20, 0);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || display_number !== e.dn) begin
      n_fail++;
      $display("FAIL sub_equal got st=%0d dn=%0d want st=%0d dn=%0d", state, display_number, e.st, e.dn);
    end
    drive(0, 0, 1, 0);
    n_tests++;
    if (arithmetic_sel !== 1'b1 || state !== 2'd2) begin
      n_fail++;
      $display("FAIL show_add_ignored got sel=%0b st=%0d want sel=1 st=2", arithmetic_sel, state);
    end
    drive(0, 1, 0, 0);
    n_tests++;
    if (arithmetic_sel !== 1'b1 || state !== 2'd0) begin
      n_fail++; $display("FAIL sel_kept got sel=%0b st=%0d want sel=1 st=0", arithmetic_sel, state);
    end
  endtask

  task automatic test_priority;
    drive(1, 0, 0, 0);
    exp_sel = 1'b0;
    n_tests++;
    if (arithmetic_sel !== 1'b0 || state !== 2'd0 || slider_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_a got sel=%0b st=%0d clr=%0b want 0/0/1", arithmetic_sel, state, slider_clr);
    end
    number_1 = 14'd6000;
    number_2 = 14'd5000;
    drive(0, 1, 0, 0);
    n_tests++;
    if (state !== 2'd1 || write_number_select !== 1'b1 || display_number !== 14'd5000) begin
      n_fail++;
      $display("FAIL enter_b got st=%0d wns=%0b dn=%0d want 1/1/5000", state, write_number_select, display_number);
    end
    drive(0, 1, 0, 1);
    n_tests++;
    if (arithmetic_sel !== 1'b0 || state !== 2'd3 || write_number_select !== 1'b0) begin
      n_fail++;
      $display("FAIL ent_sub_prio got sel=%0b st=%0d wns=%0b want 0/3/0", arithmetic_sel, state, write_number_select);
    end
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 1);
    exp_sel = 1'b1;
    n_tests++;
    if (arithmetic_sel !== 1'b1 || state !== 2'd0) begin
      n_fail++; $display("FAIL add_sub_both got sel=%0b st=%0d want 1/0", arithmetic_sel, state);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic ok;
    run_eval(14'd30, 14'd10, 0);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || display_number !== e.dn) begin
      n_fail++;
      $display("FAIL sub_pos got st=%0d dn=%0d want st=%0d dn=%0d", state, display_number, e.st, e.dn);
    end
    drive(1, 1, 0, 0);
    exp_sel = 1'b0;
    n_tests++;
    if (state !== 2'd0 || arithmetic_sel !== 1'b0 || slider_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_ent_show got st=%0d sel=%0b clr=%0b want 0/0/1", state, arithmetic_sel, slider_clr);
    end
    @(negedge clk);
    n_tests++;
    if (slider_clr !== 1'b0) begin
      n_fail++; $display("FAIL clr_ent_width got %0b want 0", slider_clr);
    end
    run_eval(14'd10, 14'd20, 2);
    wait_done(ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || state !== e.st || arithmetic_sel !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_err got st=%0d sel=%0b want st=%0d sel=1", state, arithmetic_sel, e.st);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({state, arithmetic_sel, write_number_select, slider_clr, display_blank} !== 6'b0 ||
        display_number !== '0) begin
      n_fail++;
      $display("FAIL reset_in_error got st=%0d sel=%0b wns=%0b clr=%0b blank=%0b dn=%0d want all 0",
               state, arithmetic_sel, write_number_select, slider_clr, display_blank, display_number);
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_boundary();
    test_blink();
    test_sub();
    test_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
